issue_scoreboard: RTL and testbench

//  Issue-stage hazard scheduler sitting between decode and execute. Tracks in-flight writes to
//  the 64-entry unified register space (id[5]=1 FPR, 0 GPR) using each instruction's wait_time,

---
 rtl/issue_scoreboard_pkg.sv | 28 ++
 rtl/sb_wb_slot_pipe.sv | 37 +++
 rtl/issue_scoreboard.sv | 88 ++++++++
 tb/tb_issue_scoreboard.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared encodings and types for the issue-stage scoreboard.
package issue_scoreboard_pkg;

  localparam int unsigned WAIT_W   = 5;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned ID_W     = 6;
  localparam int unsigned NUM_REGS = 64;

  // Destination-class encoding reused from decode's wait_time/rw fields.
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GPR  = 2'b01;
  localparam logic [1:0] RW_FPR  = 2'b10;

  // Unified register id: {fpr, idx}.
  typedef logic [ID_W-1:0] reg_id_t;

  // One writeback-slot entry.
  typedef struct packed {
    logic    valid;
    reg_id_t id;
  } wb_slot_t;

  // A wait of zero still takes one cycle to reach the regfile.
  function automatic logic [WAIT_W-1:0] eff_wait(input logic [WAIT_W-1:0] w);
    return (w == '0) ? WAIT_W'(1) : w;
  endfunction

endpackage

// File: rtl/sb_wb_slot_pipe.sv
// Shift register of pending regfile writes; head is the write landing this cycle.
module sb_wb_slot_pipe
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ins_en,
  input  logic [WAIT_W-1:0] ins_idx,
  input  reg_id_t           ins_id,
  output wb_slot_t          head,
  output logic [DEPTH-1:0]  occupied
);

  wb_slot_t slot_q [DEPTH];

  // Advance one slot per cycle; a new write overrides the shifted-in entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < DEPTH; k++) slot_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH - 1; k++) slot_q[k] <= slot_q[k+1];
      slot_q[DEPTH-1] <= '0;
      if (ins_en) slot_q[ins_idx] <= '{valid: 1'b1, id: ins_id};
    end
  end

  assign head = slot_q[0];

  // Occupancy view used for the write-port conflict check.
  always_comb begin
    occupied = '0;
    for (int unsigned k = 0; k < DEPTH; k++) occupied[k] = slot_q[k].valid;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard scheduler: RAW/WAW/write-port stalls and expected writeback.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter bit          FWD_BYPASS = 1'b1,
  parameter int unsigned WAIT_MAX   = 31
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                dec_valid,
  input  logic [ID_W-1:0]     dec_rs,
  input  logic [ID_W-1:0]     dec_rt,
  input  logic                dec_uses_s,
  input  logic                dec_uses_t,
  input  logic [1:0]          dec_rw,
  input  logic [IDX_W-1:0]    dec_rd,
  input  logic [WAIT_W-1:0]   dec_wait,
  input  logic                flush,
  output logic                issue,
  output logic                stall,
  output logic                wb_expect,
  output logic [ID_W-1:0]     wb_expect_id,
  output logic [NUM_REGS-1:0] busy_mask
);

  localparam int unsigned DEPTH = WAIT_MAX + 1;

  logic [WAIT_W-1:0] cnt_q [NUM_REGS];
  logic [WAIT_W-1:0] w_eff;
  reg_id_t           dst;
  logic              wr;
  logic              ready_s;
  logic              ready_t;
  logic              waw;
  logic              port_conflict;
  logic [DEPTH-1:0]  slot_occ;
  wb_slot_t          head;

  // A source is ready once its write is done, or landing now when forwarded.
  function automatic logic src_ready(input logic [WAIT_W-1:0] c);
    return (c == '0) || (FWD_BYPASS && (c == WAIT_W'(1)));
  endfunction

  // Hazard evaluation and issue decision for the instruction at decode.
  always_comb begin
    w_eff         = eff_wait(dec_wait);
    wr            = (dec_rw == RW_GPR) || (dec_rw == RW_FPR);
    dst           = {dec_rw == RW_FPR, dec_rd};
    ready_s       = !dec_uses_s || src_ready(cnt_q[dec_rs]);
    ready_t       = !dec_uses_t || src_ready(cnt_q[dec_rt]);
    waw           = wr && (cnt_q[dst] > w_eff);
    port_conflict = wr && slot_occ[w_eff];
    stall         = dec_valid && (!ready_s || !ready_t || waw || port_conflict);
    issue         = dec_valid && !flush && !stall;
  end

  // Per-register countdown to the pending write; a new issue reloads it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (cnt_q[r] != '0) cnt_q[r] <= cnt_q[r] - WAIT_W'(1);
      end
      if (issue && wr) cnt_q[dst] <= w_eff;
    end
  end

  // Busy view of the countdowns.
  always_comb begin
    busy_mask = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) busy_mask[r] = (cnt_q[r] != '0);
  end

  sb_wb_slot_pipe #(.DEPTH(DEPTH)) u_slot_pipe (
    .clk      (clk),
    .rstn     (rstn),
    .ins_en   (issue && wr),
    .ins_idx  (w_eff - WAIT_W'(1)),
    .ins_id   (dst),
    .head     (head),
    .occupied (slot_occ)
  );

  assign wb_expect    = head.valid;
  assign wb_expect_id = head.id;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed table, reset sequence, randomized vs. model.
module tb_issue_scoreboard;

  localparam int WAIT_MAX = 31;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dec_valid;
  logic [5:0]  dec_rs, dec_rt;
  logic        dec_uses_s, dec_uses_t;
  logic [1:0]  dec_rw;
  logic [4:0]  dec_rd, dec_wait;
  logic        flush;
  logic        issue, stall, wb_expect;
  logic [5:0]  wb_expect_id;
  logic [63:0] busy_mask;

  issue_scoreboard #(.FWD_BYPASS(1'b1), .WAIT_MAX(31)) dut (
    .clk(clk), .rstn(rstn), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_uses_s(dec_uses_s), .dec_uses_t(dec_uses_t), .dec_rw(dec_rw), .dec_rd(dec_rd),
    .dec_wait(dec_wait), .flush(flush), .issue(issue), .stall(stall),
    .wb_expect(wb_expect), .wb_expect_id(wb_expect_id), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [5:0] rs, rt;
    logic       us, ut;
    logic [1:0] rw;
    logic [4:0] rd, wt;
    logic       fl;
    logic       e_iss, e_stl, e_wb;
    logic [5:0] e_id;
  } vec_t;

  typedef struct {
    int         land;
    logic [5:0] id;
  } rec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_land [64];
  rec_t pend [$];
  vec_t tbl [$];

  function automatic vec_t mk(logic v, logic [5:0] rs, logic [5:0] rt, logic us, logic ut,
                              logic [1:0] rw, logic [4:0] rd, logic [4:0] wt, logic fl,
                              logic ei, logic es, logic ew, logic [5:0] eid);
    vec_t x;
    x.v = v; x.rs = rs; x.rt = rt; x.us = us; x.ut = ut; x.rw = rw; x.rd = rd; x.wt = wt;
    x.fl = fl; x.e_iss = ei; x.e_stl = es; x.e_wb = ew; x.e_id = eid;
    return x;
  endfunction

  function automatic vec_t idle(logic ew, logic [5:0] eid);
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, ew, eid);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    for (int i = 0; i < 64; i++) last_land[i] = -100;
  endtask

  // Drive one cycle, compare against the model (and table values if given), then commit.
  task automatic step(input vec_t v, input bit use_tbl);
    int         w;
    bit         wr, rdy_s, rdy_t, waw, port, m_stall, m_issue, m_wb;
    logic [5:0] dst, m_id;
    logic [63:0] m_busy;
    dec_valid = v.v; dec_rs = v.rs; dec_rt = v.rt; dec_uses_s = v.us; dec_uses_t = v.ut;
    dec_rw = v.rw; dec_rd = v.rd; dec_wait = v.wt; flush = v.fl;
    assert (int'(v.wt) <= WAIT_MAX) else $error("dec_wait beyond WAIT_MAX");
    @(negedge clk);
    w     = (v.wt == 0) ? 1 : int'(v.wt);
    wr    = (v.rw == 2'b01) || (v.rw == 2'b10);
    dst   = {v.rw == 2'b10, v.rd};
    rdy_s = !v.us || (last_land[v.rs] <= cyc);
    rdy_t = !v.ut || (last_land[v.rt] <= cyc);
    waw   = wr && (last_land[dst] >= cyc + w);
    port  = 1'b0;
    m_wb  = 1'b0;
    m_id  = '0;
    foreach (pend[i]) begin
      if (wr && pend[i].land == cyc + w) port = 1'b1;
      if (pend[i].land == cyc) begin m_wb = 1'b1; m_id = pend[i].id; end
    end
    m_stall = v.v && (!rdy_s || !rdy_t || waw || port);
    m_issue = v.v && !v.fl && !m_stall;
    for (int i = 0; i < 64; i++) m_busy[i] = (last_land[i] >= cyc);
    chk("issue", 64'(issue), 64'(m_issue));
    chk("stall", 64'(stall), 64'(m_stall));
    chk("wb_expect", 64'(wb_expect), 64'(m_wb));
    chk("wb_expect_id", 64'(wb_expect_id), 64'(m_id));
    chk("busy_mask", busy_mask, m_busy);
    if (use_tbl) begin
      chk("tbl_issue", 64'(issue), 64'(v.e_iss));
      chk("tbl_stall", 64'(stall), 64'(v.e_stl));
      chk("tbl_wb", 64'(wb_expect), 64'(v.e_wb));
      chk("tbl_wb_id", 64'(wb_expect_id), 64'(v.e_id));
    end
    @(posedge clk);
    if (m_issue && wr) begin
      pend.push_back('{land: cyc + w, id: dst});
      last_land[dst] = cyc + w;
    end
    cyc++;
    for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].land < cyc) pend.delete(i);
    #1;
  endtask

  initial begin
    vec_t rv;
    model_clear();
    // RAW on r3 with bypass; also a wb check on r3
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'b01, 3, 3, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 1, 0, 2'b00, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 0, 1, 0, 2'b00, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 0, 1, 0, 2'b00, 0, 1, 0, 1, 0, 1, 6'd3));
    // Write-port conflict
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'b10, 5, 6, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(idle(0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 1, 0, 1, 6'h25));
    tbl.push_back(idle(1, 6'd1));
    // WAW on f2
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'b10, 2, 6, 0, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 2'b10, 2, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'b10, 2, 1, 0, 1, 0, 1, 6'h22));
    tbl.push_back(idle(1, 6'h22));
    // File separation, f3 vs r3; unused source never stalls
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'b10, 3, 6, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 3, 3, 1, 1, 2'b00, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 6'h23, 0, 1, 0, 2'b00, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 6'h23, 0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(1, 6'h23));
    // wb check on r7
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'b01, 7, 3, 0, 1, 0, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(1, 6'd7));
    tbl.push_back(idle(0, 0));
    // Flush leaves no state behind
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'b01, 9, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 9, 0, 1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    // Zero wait behaves as one; rw=11 is not a write
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'b01, 10, 0, 0, 1, 0, 0, 0));
    tbl.push_back(idle(1, 6'd10));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'b11, 11, 1, 0, 1, 0, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));

    // Reset state
    rstn = 1'b0;
    dec_valid = 1'b1; dec_rs = '0; dec_rt = '0; dec_uses_s = 1'b0; dec_uses_t = 1'b0;
    dec_rw = 2'b01; dec_rd = 5'd4; dec_wait = 5'd3; flush = 1'b0;
    #2;
    chk("rst_busy", busy_mask, 64'd0);
    chk("rst_wb", 64'(wb_expect), 64'd0);
    chk("rst_wb_id", 64'(wb_expect_id), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_issue", 64'(issue), 64'd1);
    dec_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // Reset in the middle of two in-flight writes
    step(mk(1, 0, 0, 0, 0, 2'b01, 20, 9, 0, 0, 0, 0, 0), 1'b0);
    step(mk(1, 0, 0, 0, 0, 2'b10, 21, 12, 0, 0, 0, 0, 0), 1'b0);
    step(idle(0, 0), 1'b0);
    chk("pre_rst_busy", busy_mask, 64'h0020_0000_0010_0000);
    #2;
    rstn = 1'b0;
    dec_valid = 1'b1; dec_rw = 2'b01; dec_rd = 5'd20; dec_wait = 5'd5; flush = 1'b0;
    dec_uses_s = 1'b0; dec_uses_t = 1'b0;
    #1;
    chk("midrst_busy", busy_mask, 64'd0);
    chk("midrst_wb", 64'(wb_expect), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_issue", 64'(issue), 64'd1);
    dec_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
    @(posedge clk);
    cyc++;
    #1;
    step(mk(1, 6'd20, 6'h35, 1, 1, 2'b01, 20, 1, 0, 1, 0, 0, 0), 1'b1);
    step(idle(1, 6'd20), 1'b1);

    // Randomized traffic on a small register set to provoke hazards
    for (int n = 0; n < 600; n++) begin
      rv.v  = ($urandom % 4) != 0;
      rv.rs = {1'($urandom), 5'($urandom % 4)};
      rv.rt = {1'($urandom), 5'($urandom % 4)};
      rv.us = 1'($urandom);
      rv.ut = 1'($urandom);
      rv.rw = 2'($urandom);
      rv.rd = 5'($urandom % 4);
      rv.wt = (($urandom % 8) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 8));
      rv.fl = ($urandom % 8) == 0;
      rv.e_iss = 0; rv.e_stl = 0; rv.e_wb = 0; rv.e_id = 0;
      step(rv, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
